// File: rtl/fmap_pkg.sv
// Shared constants, derivation helpers and FSM state type for the feature-map output collector.
package fmap_pkg;

    localparam int FD_DEF       = 512;
    localparam int N_PE_DEF     = 4;
    localparam int IN_WIDTH_DEF = 1;
    localparam int DEPTH_DEF    = 2;

    localparam int LANE_ELEMS = FD_DEF / N_PE_DEF;
    localparam int LANE_W     = IN_WIDTH_DEF * LANE_ELEMS;
    localparam int OUT_W      = IN_WIDTH_DEF * FD_DEF;

    typedef enum logic [0:0] {
        FILL      = 1'b0,
        FULL_WAIT = 1'b1
    } state_t;

    function automatic int calc_lane_elems(input int fd, input int n_pe);
        return fd / n_pe;
    endfunction

endpackage

// File: rtl/fmap_lane_shiftreg.sv
// One PE lane: right-shifting element register with a zero-filled, slot-0-aligned flush view.
import fmap_pkg::*;

module fmap_lane_shiftreg #(
    parameter int IN_WIDTH   = 1,
    parameter int LANE_ELEMS = 128,
    parameter int CNT_W      = 8,
    localparam int LANE_BITS = IN_WIDTH * LANE_ELEMS
) (
    input  logic                 clk,
    input  logic                 clear,
    input  logic                 shift_en,
    input  logic [IN_WIDTH-1:0]  din,
    input  logic [CNT_W-1:0]     fill_cnt,
    output logic [LANE_BITS-1:0] aligned
);

    logic [LANE_BITS-1:0] lane_reg;
    logic [LANE_BITS-1:0] shifted;

    generate
        if (LANE_ELEMS == 1) begin : g_single
            assign shifted = shift_en ? din : lane_reg;
        end else begin : g_multi
            assign shifted = shift_en ? {din, lane_reg[LANE_BITS-1:IN_WIDTH]} : lane_reg;
        end
    endgenerate

    // Samples that have not yet travelled to slot 0 are pulled down; vacated upper slots fill with zero.
    assign aligned = shifted >> ((LANE_ELEMS - int'(fill_cnt)) * IN_WIDTH);

    always_ff @(posedge clk) begin
        if (clear) begin
            lane_reg <= '0;
        end else if (shift_en) begin
            lane_reg <= shifted;
        end
    end

endmodule

// File: rtl/fmap_out_collector.sv
// Gathers N_PE parallel lanes into FD-element words and queues them in a small valid/ready FIFO.
import fmap_pkg::*;

module fmap_out_collector #(
    parameter int FD       = FD_DEF,
    parameter int N_PE     = N_PE_DEF,
    parameter int IN_WIDTH = IN_WIDTH_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    localparam int LANE_N    = calc_lane_elems(FD, N_PE),
    localparam int LANE_BITS = IN_WIDTH * LANE_N,
    localparam int WORD_BITS = IN_WIDTH * FD,
    localparam int CNT_W     = $clog2(LANE_N + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_en,
    input  logic [N_PE*IN_WIDTH-1:0] data_in,
    output logic                     in_ready,
    input  logic                     flush,
    output logic [WORD_BITS-1:0]     data_out,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CNT_W-1:0]         elem_cnt,
    output logic                     overflow
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);

    state_t               state_reg, state_next;
    logic [CNT_W-1:0]     elem_cnt_reg, elem_cnt_next, cnt_after;
    logic [OCC_W-1:0]     occ_reg, occ_next;
    logic [PTR_W-1:0]     wr_ptr_reg, rd_ptr_reg;
    logic                 overflow_reg;
    logic [WORD_BITS-1:0] mem [DEPTH];
    logic [WORD_BITS-1:0] word_next;
    logic                 accept, flush_ok, push, pop, lane_clear;

    assign in_ready  = (state_reg == FILL);
    assign out_valid = (occ_reg != '0);
    assign data_out  = mem[rd_ptr_reg];
    assign elem_cnt  = elem_cnt_reg;
    assign overflow  = overflow_reg;

    assign accept    = in_en & in_ready;
    assign flush_ok  = flush & in_ready;
    assign cnt_after = elem_cnt_reg + CNT_W'(accept);
    // A flush that coincides with the completing sample collapses into the single full-word push.
    assign push      = (accept && cnt_after == CNT_W'(LANE_N)) || (flush_ok && cnt_after != '0);
    assign pop       = out_valid & out_ready;
    assign lane_clear = ~rst | push;

    generate
        for (genvar gi = 0; gi < N_PE; gi++) begin : g_lane
            fmap_lane_shiftreg #(
                .IN_WIDTH   (IN_WIDTH),
                .LANE_ELEMS (LANE_N),
                .CNT_W      (CNT_W)
            ) u_lane (
                .clk      (clk),
                .clear    (lane_clear),
                .shift_en (accept),
                .din      (data_in[gi*IN_WIDTH +: IN_WIDTH]),
                .fill_cnt (cnt_after),
                .aligned  (word_next[gi*LANE_BITS +: LANE_BITS])
            );
        end
    endgenerate

    always_comb begin
        elem_cnt_next = push ? '0 : cnt_after;
        occ_next      = occ_reg;
        if (push && !pop) begin
            occ_next = occ_reg + OCC_W'(1);
        end else if (pop && !push) begin
            occ_next = occ_reg - OCC_W'(1);
        end
        // in_ready is derived from next occupancy so it never depends combinationally on out_ready.
        state_next = (occ_next == OCC_W'(DEPTH)) ? FULL_WAIT : FILL;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg    <= FILL;
            elem_cnt_reg <= '0;
            occ_reg      <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            overflow_reg <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            state_reg    <= state_next;
            elem_cnt_reg <= elem_cnt_next;
            occ_reg      <= occ_next;
            overflow_reg <= overflow_reg | ((in_en | flush) & ~in_ready);
            if (push) begin
                mem[wr_ptr_reg] <= word_next;
                wr_ptr_reg <= (wr_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= (rd_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_reg + PTR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fmap_out_collector.sv
// Scoreboard bench for fmap_out_collector at FD=8, N_PE=2, IN_WIDTH=1, DEPTH=2.
module tb_fmap_out_collector;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_en;
    logic [1:0] data_in;
    logic       in_ready;
    logic       flush;
    logic [7:0] data_out;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] elem_cnt;
    logic       overflow;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q[$];
    logic [1:0] samp_m[4];
    int         k_m = 0;

    fmap_out_collector #(
        .FD(8), .N_PE(2), .IN_WIDTH(1), .DEPTH(2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_en     (in_en),
        .data_in   (data_in),
        .in_ready  (in_ready),
        .flush     (flush),
        .data_out  (data_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .elem_cnt  (elem_cnt),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Scoreboard: a pop occurs at the next rising edge whenever both are high at the falling edge.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL pop_unexpected: got %h, expected no word", data_out);
            end else begin
                logic [7:0] w;
                w = exp_q.pop_front();
                if (data_out !== w) begin
                    bad++;
                    $display("FAIL pop_data: got %h, expected %h", data_out, w);
                end else begin
                    $display("pop word %h ok", data_out);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accepted sample and/or flush; the model assembles the expected word itself.
    task automatic drive(input logic [1:0] d, input logic en, input logic fl);
        logic [7:0] w;
        in_en   = en;
        data_in = d;
        flush   = fl;
        if (en) begin
            samp_m[k_m] = d;
            k_m++;
        end
        if (k_m == 4 || (fl && k_m > 0)) begin
            w = '0;
            for (int s = 0; s < k_m; s++) begin
                for (int p = 0; p < 2; p++) begin
                    w[p*4 + s] = samp_m[s][p];
                end
            end
            exp_q.push_back(w);
            $display("push expected %h", w);
            k_m = 0;
        end
        tick();
        in_en = 1'b0;
        flush = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; in_en = 1'b0; flush = 1'b0; data_in = '0; out_ready = 1'b0;
        tick(); tick();
        total += 5;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b, expected 0", out_valid); end
        if (data_out !== 8'h00) begin bad++; $display("FAIL reset_data: got %h, expected 00", data_out); end
        if (in_ready !== 1'b1)  begin bad++; $display("FAIL reset_ready: got %b, expected 1", in_ready); end
        if (elem_cnt !== 3'd0)  begin bad++; $display("FAIL reset_cnt: got %0d, expected 0", elem_cnt); end
        if (overflow !== 1'b0)  begin bad++; $display("FAIL reset_ovf: got %b, expected 0", overflow); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_full_word();
        drive(2'b01, 1, 0); drive(2'b00, 1, 0); drive(2'b01, 1, 0); drive(2'b11, 1, 0);
        total += 3;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL full_valid: got %b, expected 1", out_valid); end
        if (data_out !== 8'h8D) begin bad++; $display("FAIL full_data: got %h, expected 8d", data_out); end
        if (elem_cnt !== 3'd0)  begin bad++; $display("FAIL full_cnt: got %0d, expected 0", elem_cnt); end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
    endtask

    task automatic test_flush();
        drive(2'b11, 1, 0); drive(2'b01, 1, 0); drive(2'b10, 1, 0);
        total++;
        if (elem_cnt !== 3'd3) begin bad++; $display("FAIL flush_precnt: got %0d, expected 3", elem_cnt); end
        drive(2'b00, 0, 1);
        total += 3;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL flush_valid: got %b, expected 1", out_valid); end
        if (data_out !== 8'h53) begin bad++; $display("FAIL flush_data: got %h, expected 53", data_out); end
        if (elem_cnt !== 3'd0)  begin bad++; $display("FAIL flush_cnt: got %0d, expected 0", elem_cnt); end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
    endtask

    task automatic test_flush_edges();
        drive(2'b00, 0, 1);
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_empty: got valid %b, expected 0", out_valid); end
        drive(2'b01, 1, 0); drive(2'b10, 1, 0); drive(2'b11, 1, 0); drive(2'b10, 1, 1);
        total += 2;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL flush_4th_valid: got %b, expected 1", out_valid); end
        if (elem_cnt !== 3'd0)  begin bad++; $display("FAIL flush_4th_cnt: got %0d, expected 0", elem_cnt); end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_4th_single: got valid %b, expected 0", out_valid); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) drive(2'($urandom_range(0, 3)), 1, 0);
        total += 2;
        if (in_ready !== 1'b0)      begin bad++; $display("FAIL bp_ready_low: got %b, expected 0", in_ready); end
        if (data_out !== exp_q[0])  begin bad++; $display("FAIL bp_head: got %h, expected %h", data_out, exp_q[0]); end
        in_en = 1'b1; data_in = 2'b11; tick(); in_en = 1'b0;
        total += 2;
        if (overflow !== 1'b1) begin bad++; $display("FAIL bp_overflow: got %b, expected 1", overflow); end
        if (elem_cnt !== 3'd0) begin bad++; $display("FAIL bp_cnt_hold: got %0d, expected 0", elem_cnt); end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        total += 3;
        if (in_ready !== 1'b1)     begin bad++; $display("FAIL bp_ready_back: got %b, expected 1", in_ready); end
        if (out_valid !== 1'b1)    begin bad++; $display("FAIL bp_second_valid: got %b, expected 1", out_valid); end
        if (data_out !== exp_q[0]) begin bad++; $display("FAIL bp_second: got %h, expected %h", data_out, exp_q[0]); end
    endtask

    task automatic test_push_pop();
        drive(2'b10, 1, 0); drive(2'b01, 1, 0); drive(2'b11, 1, 0);
        out_ready = 1'b1;
        drive(2'b10, 1, 0);
        out_ready = 1'b0;
        total += 3;
        if (out_valid !== 1'b1)    begin bad++; $display("FAIL pp_valid: got %b, expected 1", out_valid); end
        if (in_ready !== 1'b1)     begin bad++; $display("FAIL pp_ready: got %b, expected 1", in_ready); end
        if (data_out !== exp_q[0]) begin bad++; $display("FAIL pp_order: got %h, expected %h", data_out, exp_q[0]); end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL pp_drained: got %b, expected 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 6; i++) drive(2'($urandom_range(0, 3)), 1, 0);
        total++;
        if (elem_cnt !== 3'd2) begin bad++; $display("FAIL mid_precnt: got %0d, expected 2", elem_cnt); end
        rst = 1'b0; tick(); rst = 1'b1;
        exp_q.delete();
        k_m = 0;
        total += 5;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_valid: got %b, expected 0", out_valid); end
        if (elem_cnt !== 3'd0)  begin bad++; $display("FAIL mid_cnt: got %0d, expected 0", elem_cnt); end
        if (data_out !== 8'h00) begin bad++; $display("FAIL mid_data: got %h, expected 00", data_out); end
        if (in_ready !== 1'b1)  begin bad++; $display("FAIL mid_ready: got %b, expected 1", in_ready); end
        if (overflow !== 1'b0)  begin bad++; $display("FAIL mid_ovf: got %b, expected 0", overflow); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) drive(2'($urandom_range(0, 3)), 1, 0);
        tick(); tick(); tick();
        out_ready = 1'b0;
        total += 2;
        if (exp_q.size() != 0) begin bad++; $display("FAIL b2b_left: got %0d words pending, expected 0", exp_q.size()); end
        if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready: got %b, expected 1", in_ready); end
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_flush();
        test_flush_edges();
        test_backpressure();
        test_push_pop();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fmap_out_collector.md
# fmap_out_collector

Multi-lane, handshaked successor to the PE output shift buffer. Gathers IN_WIDTH-bit results from N_PE processing elements in parallel, one lane per PE, into FD-element feature-map words. Queues completed words in a DEPTH-entry output FIFO with valid/ready flow control. Supports flushing a partially filled word, with zero fill. Sits between the PE array and the next layer's input shift register.

## Interface
- FD, 512: elements per output word (feature-map depth); must be a multiple of N_PE.
- N_PE, 4: number of PE lanes.
- IN_WIDTH, 1: bits per element.
- DEPTH, 2: output FIFO entries, ≥1.
- Derived: LANE_ELEMS = FD/N_PE; LANE_W = IN_WIDTH·LANE_ELEMS; OUT_W = IN_WIDTH·FD.
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  reset, synchronous, active-low.
- in_en  in  1  sample strobe; all lanes present one element each.
- data_in  in  N_PE·IN_WIDTH  lane p at [p·IN_WIDTH +: IN_WIDTH].
- in_ready  out  1  collector can accept in_en / flush.
- flush  in  1  close the current partial word.
- data_out  out  OUT_W  FIFO head word.
- out_valid  out  1  data_out holds a valid word.
- out_ready  in  1  consumer accepts the head word.
- elem_cnt  out  clog2(LANE_ELEMS+1)  elements in the current partial word.
- overflow  out  1  sticky: in_en or flush arrived while in_ready=0.

## Operation
- Lane p owns data_out bits [p·LANE_W +: LANE_W].
- Each accepted in_en shifts every lane right by IN_WIDTH. New data enters at the lane MSB. After a full word, the first sample sits in lane slot 0 (LSBs).
- Accepted means in_en=1 and in_ready=1. elem_cnt increments on each accepted in_en.
- When an accepted in_en brings elem_cnt to LANE_ELEMS, the assembled word (including this sample) is pushed into the FIFO and elem_cnt returns to 0.
- Flush with elem_cnt=k, 0<k<LANE_ELEMS: each lane is right-shifted by (LANE_ELEMS−k)·IN_WIDTH. Samples land in slots 0..k−1, upper slots are zero. The word is pushed and elem_cnt goes to 0.
- Flush with elem_cnt=0: no-op, nothing pushed.
- in_en and flush in the same cycle: the sample is absorbed first, then the flush applies with k+1. If k+1=LANE_ELEMS, it is a normal full push (single push).
- FSM states:
  - FILL: accepting samples.
  - FULL_WAIT: entered when the FIFO holds DEPTH words. in_ready=0. Returns to FILL the cycle after a pop.
- In FULL_WAIT the lane registers and elem_cnt hold. In_en and flush are ignored and set overflow.
- Pop: out_valid=1 and out_ready=1 removes the head word.
- Push and pop in the same cycle: occupancy is unchanged.
- Arithmetic: elem_cnt and the FIFO pointers wrap modulo their range. FIFO pointers use clog2(DEPTH) bits plus an occupancy counter, which is 0..DEPTH.

## Timing
- Reset (rst=0 at clk edge) forces the following, regardless of any operation in progress; a partial word and all queued words are discarded:
  - lanes=0, elem_cnt=0, FIFO empty;
  - out_valid=0, data_out=0, in_ready=1, overflow=0;
  - state FILL.
- Push latency: out_valid rises the cycle after the completing in_en or flush edge. data_out is stable while out_valid=1 and out_ready=0.
- in_ready is registered and equals (occupancy<DEPTH). It falls the cycle after the push that fills the FIFO. There is no combinational path from out_ready to in_ready.
- Throughput: one sample per cycle sustained while the consumer pops at least one word per LANE_ELEMS cycles.
- data_out comes straight from the FIFO head register; there is no output mux stage beyond the read pointer select.

## Structure
- Shared package `fmap_pkg`: the derived constants LANE_ELEMS, LANE_W, OUT_W, and the state enum {FILL, FULL_WAIT}.
- Sub-module `fmap_lane_shiftreg`, instantiated N_PE times, holds one lane register:
  - shift-in on accepted in_en;
  - aligned flush output;
  - synchronous clear.
- FIFO storage and the FSM stay in the top module.

## Test plan
- FD=8, N_PE=2, IN_WIDTH=1, DEPTH=2. Drive four accepted in_en with lane0 = 1,0,1,1 and lane1 = 0,0,0,1 → one cycle later out_valid=1, data_out=8'h8D, elem_cnt=0.
- Same config, three samples lane0 = 1,1,0 and lane1 = 1,0,1, then flush → data_out=8'h53 (lane0 4'b0011, lane1 4'b0101).
- Push 2 words with out_ready=0 → in_ready=0 from the cycle after the 2nd push. A further in_en → overflow=1, lanes unchanged. Assert out_ready for 1 cycle → in_ready=1 the next cycle, 1st word popped.
- Simultaneous push and pop at occupancy 1 → occupancy stays 1, word order preserved.
- rst=0 asserted mid-word (elem_cnt=2) with 1 word queued → next cycle out_valid=0, elem_cnt=0, data_out=0, in_ready=1.
- Flush at elem_cnt=0 → no push. Flush together with the 4th in_en → exactly one word pushed.
